// File: rtl/plru_table.sv
// -----------------------------------------------------------------------------
// plru_table
//
// Per-set tree pseudo-LRU store for an N-way set-associative cache.
// Each set owns a (Way-1)-bit tree. Hit accesses turn the nodes on their path
// away from the accessed way. A victim request walks the tree from the root,
// returns the chosen way one cycle later, and marks that way as used.
//
// Optional feature (compile-time macro PLRU_LOCK_EN):
//   adds lock_i. The walk avoids subtrees whose ways are all locked. When
//   every way is locked, the lock mask is ignored.
//
// Ports:
//   clk          clock, all state on rising edge
//   reset        asynchronous active-high reset
//   acc_valid_i  hit access strobe
//   acc_set_i    set of the hit access
//   acc_way_i    way of the hit access
//   vic_req_i    victim request, accepted only while ready_o=1
//   vic_set_i    set for the victim request
//   vic_valid_o  one-cycle pulse, the victim response is valid
//   vic_way_o    victim way, held while vic_valid_o=0
//   flush_i      start clearing all trees, accepted only while ready_o=1
//   ready_o      table idle and accepting traffic
//   lock_i       per-way lock mask (only with PLRU_LOCK_EN)
// -----------------------------------------------------------------------------
module plru_table #(
    parameter int Way      = 8,
    parameter int Sets     = 64,
    parameter int LruStatW = Way - 1,
    parameter int WaySel   = $clog2(Way),
    parameter int SetSel   = $clog2(Sets)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc_valid_i,
    input  logic [SetSel-1:0] acc_set_i,
    input  logic [WaySel-1:0] acc_way_i,
    input  logic              vic_req_i,
    input  logic [SetSel-1:0] vic_set_i,
    output logic              vic_valid_o,
    output logic [WaySel-1:0] vic_way_o,
    input  logic              flush_i,
    output logic              ready_o
`ifdef PLRU_LOCK_EN
    ,
    input  logic [Way-1:0]    lock_i
`endif
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t              state, state_next;
    logic [SetSel-1:0]   flush_cnt;
    logic [LruStatW-1:0] tree [Sets];

    // Turn every node on the path to 'way' so that it points away from it.
    function automatic logic [LruStatW-1:0] tree_update(
        input logic [LruStatW-1:0] stat,
        input logic [WaySel-1:0]   way
    );
        logic [LruStatW-1:0] s;
        logic [WaySel-1:0]   ni;
        logic                wb;
        int                  node;
        s = stat;
        for (int k = 0; k < WaySel; k++) begin
            node = (1 << k) - 1 + (int'(way) >> (WaySel - k));
            ni   = WaySel'(node);
            wb   = ((int'(way) >> (WaySel - 1 - k)) & 1) != 0;
            if (s[ni] == wb) begin
                s[ni] = ~wb;
            end
        end
        return s;
    endfunction

    // Walk from the root. w holds the branch bits chosen so far, right
    // aligned, so at level k it is also the node offset within that level.
    function automatic logic [WaySel-1:0] tree_victim(
        input logic [LruStatW-1:0] stat,
        input logic [Way-1:0]      lock
    );
        logic [WaySel-1:0] w;
        logic [WaySel-1:0] ni;
        logic [WaySel-1:0] wj;
        logic              b;
        logic              lo_all;
        logic              hi_all;
        int                node;
        w = '0;
        for (int k = 0; k < WaySel; k++) begin
            node   = (1 << k) - 1 + int'(w);
            ni     = WaySel'(node);
            b      = stat[ni];
            lo_all = 1'b1;
            hi_all = 1'b1;
            for (int j = 0; j < Way; j++) begin
                if ((j >> (WaySel - k)) == int'(w)) begin
                    wj = WaySel'(j);
                    if (((j >> (WaySel - 1 - k)) & 1) == 0) begin
                        lo_all = lo_all & lock[wj];
                    end else begin
                        hi_all = hi_all & lock[wj];
                    end
                end
            end
            // A fully locked branch is skipped. Both branches cannot be fully
            // locked, because an all-ones mask is cleared before the walk.
            if (!b && lo_all) begin
                b = 1'b1;
            end else if (b && hi_all) begin
                b = 1'b0;
            end
            w = WaySel'({w, b});
        end
        return w;
    endfunction

    logic                acc_fire;
    logic                vic_fire;
    logic                same_set;
    logic [LruStatW-1:0] acc_new;
    logic [LruStatW-1:0] vic_stat;
    logic [LruStatW-1:0] vic_new;
    logic [WaySel-1:0]   victim;
    logic [Way-1:0]      lock_eff;

    always_comb begin
`ifdef PLRU_LOCK_EN
        lock_eff = (&lock_i) ? '0 : lock_i;
`else
        lock_eff = '0;
`endif
        // flush_i wins over traffic presented in the same cycle.
        acc_fire = ready_o && acc_valid_i && !flush_i;
        vic_fire = ready_o && vic_req_i && !flush_i;
        same_set = (acc_set_i == vic_set_i);
        acc_new  = tree_update(tree[acc_set_i], acc_way_i);
        // A same-set victim sees the access that happens in the same cycle.
        vic_stat = (acc_fire && same_set) ? acc_new : tree[vic_set_i];
        victim   = tree_victim(vic_stat, lock_eff);
        vic_new  = tree_update(vic_stat, victim);
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (flush_i) state_next = FLUSH;
            FLUSH:   if (flush_cnt == SetSel'(Sets - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready_o = (state == IDLE);
    end

    // The counter is 0 whenever the FSM is idle, so a flush starts at set 0.
    // It wraps back to 0 on its last flush cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt <= '0;
        end else if (state == FLUSH) begin
            flush_cnt <= flush_cnt + 1'b1;
        end else begin
            flush_cnt <= '0;
        end
    end

    // The victim write-back already includes a same-set access, so the
    // access writes on its own only when it targets a different set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Sets; i++) begin
                tree[i] <= '0;
            end
        end else if (state == FLUSH) begin
            tree[flush_cnt] <= '0;
        end else begin
            if (acc_fire && !(vic_fire && same_set)) begin
                tree[acc_set_i] <= acc_new;
            end
            if (vic_fire) begin
                tree[vic_set_i] <= vic_new;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vic_valid_o <= 1'b0;
            vic_way_o   <= '0;
        end else begin
            vic_valid_o <= vic_fire;
            if (vic_fire) begin
                vic_way_o <= victim;
            end
        end
    end

endmodule

// File: tb/tb_plru_table.sv
// -----------------------------------------------------------------------------
// tb_plru_table
//
// Randomized and directed stimulus for plru_table. A reference model holds
// per-set node bits and finds victims by halving way ranges. Expected victims
// are queued with their due cycle. A monitor on the falling edge checks them.
// -----------------------------------------------------------------------------
module tb_plru_table;

    localparam int Way      = 8;
    localparam int Sets     = 64;
    localparam int LruStatW = Way - 1;
    localparam int WaySel   = $clog2(Way);
    localparam int SetSel   = $clog2(Sets);

    logic              clk;
    logic              reset;
    logic              acc_valid_i;
    logic [SetSel-1:0] acc_set_i;
    logic [WaySel-1:0] acc_way_i;
    logic              vic_req_i;
    logic [SetSel-1:0] vic_set_i;
    logic              vic_valid_o;
    logic [WaySel-1:0] vic_way_o;
    logic              flush_i;
    logic              ready_o;
    logic [Way-1:0]    lock;

    plru_table #(.Way(Way), .Sets(Sets)) dut (
        .clk         (clk),
        .reset       (reset),
        .acc_valid_i (acc_valid_i),
        .acc_set_i   (acc_set_i),
        .acc_way_i   (acc_way_i),
        .vic_req_i   (vic_req_i),
        .vic_set_i   (vic_set_i),
        .vic_valid_o (vic_valid_o),
        .vic_way_o   (vic_way_o),
        .flush_i     (flush_i),
        .ready_o     (ready_o)
`ifdef PLRU_LOCK_EN
        ,
        .lock_i      (lock)
`endif
    );

    typedef struct {
        int due;
        int way;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_way = 0;
    int   flush_left = 0;
    bit   m_tree [Sets][LruStatW];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic int lock_mask();
`ifdef PLRU_LOCK_EN
        if (lock == {Way{1'b1}}) return 0;
        return int'(lock);
`else
        return 0;
`endif
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < Sets; s++)
            for (int n = 0; n < LruStatW; n++)
                m_tree[s][n] = 1'b0;
    endfunction

    function automatic void m_update(input int s, input int way);
        int node;
        bit b;
        for (int k = 0; k < WaySel; k++) begin
            node = (1 << k) - 1 + (way >> (WaySel - k));
            b = ((way >> (WaySel - 1 - k)) & 1) != 0;
            if (m_tree[s][node] == b) m_tree[s][node] = !b;
        end
    endfunction

    function automatic int m_victim(input int s);
        int lo = 0;
        int hi = Way;
        int k = 0;
        int mid;
        int node;
        int lk = lock_mask();
        bit go_hi;
        bit lo_lk;
        bit hi_lk;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            node = (1 << k) - 1 + (lo >> (WaySel - k));
            go_hi = m_tree[s][node];
            lo_lk = 1'b1;
            hi_lk = 1'b1;
            for (int w = lo; w < mid; w++) if (((lk >> w) & 1) == 0) lo_lk = 1'b0;
            for (int w = mid; w < hi; w++) if (((lk >> w) & 1) == 0) hi_lk = 1'b0;
            if (!go_hi && lo_lk) go_hi = 1'b1;
            else if (go_hi && hi_lk) go_hi = 1'b0;
            if (go_hi) lo = mid;
            else hi = mid;
            k++;
        end
        return lo;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                checks++;
                if (!vic_valid_o || int'(vic_way_o) != e.way) begin
                    errors++;
                    $display("FAIL victim cyc=%0d got valid=%0b way=%0d want valid=1 way=%0d",
                             cyc, vic_valid_o, vic_way_o, e.way);
                end
                last_way = e.way;
            end else begin
                checks++;
                if (vic_valid_o) begin
                    errors++;
                    $display("FAIL spurious_valid cyc=%0d got valid=1 way=%0d want valid=0",
                             cyc, vic_way_o);
                end else if (int'(vic_way_o) != last_way) begin
                    errors++;
                    $display("FAIL way_hold cyc=%0d got way=%0d want %0d", cyc, vic_way_o, last_way);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit av, input int as, input int aw,
                        input bit vr, input int vs, input bit fl);
        bit   m_ready;
        int   v;
        exp_t e;
        acc_valid_i = av;
        acc_set_i   = SetSel'(as);
        acc_way_i   = WaySel'(aw);
        vic_req_i   = vr;
        vic_set_i   = SetSel'(vs);
        flush_i     = fl;
        m_ready = (flush_left == 0);
        checks++;
        if (ready_o !== m_ready) begin
            errors++;
            $display("FAIL ready cyc=%0d got %0b want %0b", cyc, ready_o, m_ready);
        end
        if (!m_ready) begin
            flush_left--;
        end else if (fl) begin
            m_clear();
            flush_left = Sets;
        end else begin
            if (av) m_update(as, aw);
            if (vr) begin
                v = m_victim(vs);
                m_update(vs, v);
                e.due = cyc + 1;
                e.way = v;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Drives reset asynchronously and checks the outputs before any clock edge.
    task automatic do_reset();
        acc_valid_i = 0;
        vic_req_i   = 0;
        flush_i     = 0;
        reset = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1 || vic_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got ready=%0b valid=%0b want ready=1 valid=0",
                     ready_o, vic_valid_o);
        end
        m_clear();
        q.delete();
        last_way = 0;
        flush_left = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        acc_valid_i = 0;
        acc_set_i   = '0;
        acc_way_i   = '0;
        vic_req_i   = 0;
        vic_set_i   = '0;
        flush_i     = 0;
        lock        = '0;
        reset       = 1'b1;
        #2;
        do_reset();

        // Eight victim requests to set 0: 0,4,2,6,1,5,3,7.
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0);
        idle(2);

        // Set 5: access way 3, then request a victim (4).
        step(1, 5, 3, 0, 0, 0);
        step(0, 0, 0, 1, 5, 0);
        idle(1);

        // Set 2: access way 0 with a victim request in the same cycle, then another request.
        step(1, 2, 0, 1, 2, 0);
        step(0, 0, 0, 1, 2, 0);
        idle(1);

        // Access and victim request to different sets in the same cycle.
        step(1, 9, 6, 1, 8, 0);
        step(0, 0, 0, 1, 9, 0);
        idle(1);

        // Populate set 63, then flush. Requests made during the flush are dropped.
        step(1, 63, 5, 0, 0, 0);
        step(0, 0, 0, 1, 63, 0);
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < Sets; i++) step(0, 0, 0, 1, 63, 0);
        step(0, 0, 0, 1, 63, 0);
        idle(1);

        // Flush together with an access and a request: the flush wins.
        step(1, 7, 2, 1, 7, 1);
        idle(Sets);
        step(0, 0, 0, 1, 7, 0);
        idle(1);

`ifdef PLRU_LOCK_EN
        lock = 8'h0F;
        step(0, 0, 0, 1, 10, 0);
        lock = 8'hFF;
        step(0, 0, 0, 1, 11, 0);
        lock = 8'h3C;
        step(0, 0, 0, 1, 12, 0);
        step(0, 0, 0, 1, 12, 0);
        lock = '0;
        idle(1);
`endif

        // Populate several sets, start a flush, and reset it at cycle 10.
        for (int s = 20; s < 30; s++) step(1, s, s % Way, 1, s + 10, 0);
        step(0, 0, 0, 0, 0, 1);
        idle(10);
        do_reset();
        for (int s = 0; s < Sets; s++) step(0, 0, 0, 1, s, 0);
        idle(1);

        // Random traffic on a few sets so that collisions are frequent.
        for (int i = 0; i < 3000; i++) begin
`ifdef PLRU_LOCK_EN
            if ($urandom_range(0, 15) == 0) lock = Way'($urandom);
`endif
            step($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, Way - 1),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                 $urandom_range(0, 299) == 0);
        end
        lock = '0;
        idle(Sets + 3);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending responses want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/plru_table.md
# plru_table

Per-set tree pseudo-LRU state store for an N-way set-associative cache. It keeps one (Way-1)-bit PLRU tree per set and updates it on every hit access. On request it returns a registered victim way and marks that way as most recently used. It sits beside the tag array in the cache controller: hits feed the access port, and refills query the victim port.

## Interface
Parameters:
- Way, 8, associativity; power of two, at least 2
- Sets, 64, number of sets; power of two
- LruStatW, Way-1, tree bits per set
- WaySel, $clog2(Way), way index width
- SetSel, $clog2(Sets), set index width

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- acc_valid_i  in  1  hit access strobe
- acc_set_i  in  SetSel  set of hit access
- acc_way_i  in  WaySel  way of hit access
- vic_req_i  in  1  victim request; accepted only when ready_o=1
- vic_set_i  in  SetSel  set for victim request
- vic_valid_o  out  1  victim response valid, one-cycle pulse
- vic_way_o  out  WaySel  selected victim way
- flush_i  in  1  start clearing all tree state; accepted only when ready_o=1
- ready_o  out  1  table idle and accepting accesses and requests
- lock_i  in  Way  per-way lock mask (only with PLRU_LOCK_EN)

## Operation
- Storage is a flop array, Sets x LruStatW, reset to all zero.
- Tree node indexing:
  - Node 0 is the root.
  - The level-k node on the path to way w is index (2^k-1) + (w >> (WaySel-k)).
- Update on an access to way w: at each path node, if the stored bit equals the way bit for that level, invert it. The node then points away from w.
- Victim traversal:
  - Start at the root. At each node, the stored bit selects the branch (0 = lower half, 1 = upper half).
  - The chosen bits, MSB first, form the victim way.
- Victim allocation: the returned victim is treated as accessed, and its path is updated in the same cycle.
- Same-cycle access and victim request to the same set:
  - Compute s1 = update(stat, acc_way_i).
  - The victim is taken from s1.
  - Write back update(s1, victim).
- Access and victim request to different sets in the same cycle: both sets are written independently.
- acc_valid_i while ready_o=0: ignored, no state change.
- vic_req_i while ready_o=0: ignored, no response.
- FSM states:
  - IDLE: ready_o=1.
  - On flush_i in IDLE: go to FLUSH, set the counter to 0, ready_o=0.
  - FLUSH: clear set[counter] to 0 each cycle and increment the counter.
  - Counter reaching Sets-1: return to IDLE on the next cycle.
  - flush_i together with an access or victim request in IDLE: flush wins. The access and request are dropped, and no vic_valid_o is produced.
- Reset mid-flush: the FSM returns to IDLE, and all state and outputs go to their reset values.

## Timing
- Reset values:
  - vic_valid_o=0, vic_way_o=0.
  - ready_o=1 (IDLE), flush counter 0.
  - All trees 0.
- Access update: visible to any read in the next cycle.
- Victim latency: a request in cycle t gives vic_valid_o=1 and vic_way_o in cycle t+1.
- vic_way_o holds its last value while vic_valid_o=0.
- Back-to-back requests to the same set in t and t+1 see the update from t, with no stale read.
- Flush timing:
  - flush_i in cycle t gives ready_o=0 from t+1 through t+Sets.
  - ready_o=1 again at t+Sets+1.

## Configuration
- PLRU_LOCK_EN defined:
  - The lock_i port exists.
  - During traversal, if every way in the selected subtree is locked, take the other branch.
  - If all ways are locked, the lock is ignored and the plain PLRU way is returned.
  - Accesses to locked ways update the tree normally.
- PLRU_LOCK_EN undefined: no lock_i port; plain traversal only.

## Test plan
- Reset, then 8 back-to-back victim requests to set 0 with Way=8 -> vic_way_o sequence 0,4,2,6,1,5,3,7, each one cycle after its request. The tree of set 0 after the first request is 0x0B.
- Fresh set 5: access way 3, then victim request -> tree 0x01 after the access, victim way 4.
- Same cycle, set 2: access way 0 plus victim request -> victim way 4; a following request returns 2.
- Populate sets 0 and 63, then flush -> ready_o low for exactly 64 cycles. A request issued during flush gets no response. Afterwards set 63 returns victim 0.
- PLRU_LOCK_EN with lock_i=0x0F on a fresh set -> victim 4. With lock_i=0xFF -> victim 0.
- Assert reset during cycle 10 of a flush -> ready_o=1 and vic_valid_o=0 immediately. Every set returns victim 0.
